// File: rtl/pcie_ingress_buffer_mgr.sv
// Ping-pong ingress buffer manager: splits a host-to-device transfer into half-sized
// chunks, requests each chunk from the host and collects completion dwords per half.
module pcie_ingress_buffer_mgr #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_xfer_stb,
  input  logic [31:0]           i_xfer_dword_size,
  input  logic                  i_xfer_abort,
  output logic                  o_xfer_done_stb,
  output logic                  o_mrd_req_stb,
  output logic                  o_mrd_req_sel,
  output logic [31:0]           o_mrd_req_dword_cnt,
  output logic                  o_buf_rdy,
  output logic [31:0]           o_buf_offset,
  input  logic                  i_buf_we,
  input  logic [31:0]           i_buf_addr,
  input  logic [31:0]           i_buf_dat,
  output logic                  o_err_addr,
  output logic [1:0]            o_buf_full,
  output logic [ADDR_WIDTH:0]   o_full_cnt_a,
  output logic [ADDR_WIDTH:0]   o_full_cnt_b,
  input  logic [ADDR_WIDTH:0]   i_rd_addr,
  output logic [31:0]           o_rd_dat,
  input  logic [1:0]            i_rd_release
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam int                CW      = ADDR_WIDTH + 1;
  localparam logic [31:0]       DEPTH_W = 32'(DEPTH);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]     CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] zext(input logic [CW-1:0] v);
    return {{(32-CW){1'b0}}, v};
  endfunction

  state_t          state_r, state_nx_s;
  logic            sel_r;
  logic [31:0]     remaining_r;
  logic [CW-1:0]   count_r, chunk_r, chunk_s;
  logic            rdy_r, err_r, req_stb_r, req_sel_r, done_r;
  logic [31:0]     offset_r, req_cnt_r, rd_dat_r;
  logic [1:0]      full_r;
  logic [CW-1:0]   full_cnt_a_r, full_cnt_b_r;
  logic            start_s, issue_req_s, accept_s, bad_wr_s, last_s, done_s, in_win_s;
  logic [31:0]     ram_r [0:2*DEPTH-1];

  // Next-state and per-cycle control decode
  always_comb begin
    state_nx_s  = state_r;
    start_s     = 1'b0;
    issue_req_s = 1'b0;
    accept_s    = 1'b0;
    bad_wr_s    = 1'b0;
    last_s      = 1'b0;
    done_s      = 1'b0;
    chunk_s     = (remaining_r >= DEPTH_W) ? DEPTH_C : remaining_r[CW-1:0];
    in_win_s    = (i_buf_addr >= offset_r) && (i_buf_addr < (offset_r + zext(chunk_r)));
    if (i_xfer_abort) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_xfer_stb && (i_xfer_dword_size == 32'd0)) begin
            state_nx_s = ST_DONE;
          end else if (i_xfer_stb) begin
            start_s    = 1'b1;
            state_nx_s = ST_REQ;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (!full_r[sel_r]) begin
            issue_req_s = 1'b1;
            state_nx_s  = ST_FILL;
          end else begin
            state_nx_s = ST_REQ;
          end
        end
        ST_FILL: begin
          if (i_buf_we && in_win_s) begin
            accept_s = 1'b1;
            if ((count_r + CNT_ONE) == chunk_r) begin
              last_s     = 1'b1;
              state_nx_s = (remaining_r == zext(chunk_r)) ? ST_DONE : ST_REQ;
            end else begin
              state_nx_s = ST_FILL;
            end
          end else if (i_buf_we) begin
            bad_wr_s   = 1'b1;
            state_nx_s = ST_FILL;
          end else begin
            state_nx_s = ST_FILL;
          end
        end
        ST_DONE: begin
          done_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Transfer bookkeeping, request outputs, half flags and read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r        <= 1'b0;
      remaining_r  <= 32'd0;
      count_r      <= CNT_ZERO;
      chunk_r      <= CNT_ZERO;
      rdy_r        <= 1'b0;
      err_r        <= 1'b0;
      offset_r     <= 32'd0;
      req_stb_r    <= 1'b0;
      req_sel_r    <= 1'b0;
      req_cnt_r    <= 32'd0;
      done_r       <= 1'b0;
      full_r       <= 2'b00;
      full_cnt_a_r <= CNT_ZERO;
      full_cnt_b_r <= CNT_ZERO;
      rd_dat_r     <= 32'd0;
    end else begin
      req_stb_r <= issue_req_s;
      done_r    <= done_s;
      rd_dat_r  <= ram_r[i_rd_addr];
      if (bad_wr_s) err_r <= 1'b1;
      if (i_xfer_abort) begin
        rdy_r       <= 1'b0;
        remaining_r <= 32'd0;
      end else if (start_s) begin
        remaining_r <= i_xfer_dword_size;
      end else if (issue_req_s) begin
        req_sel_r <= sel_r;
        req_cnt_r <= zext(chunk_s);
        chunk_r   <= chunk_s;
        count_r   <= CNT_ZERO;
        rdy_r     <= 1'b1;
        offset_r  <= sel_r ? DEPTH_W : 32'd0;
      end else if (accept_s) begin
        count_r <= count_r + CNT_ONE;
        if (last_s) begin
          rdy_r       <= 1'b0;
          remaining_r <= remaining_r - zext(chunk_r);
          sel_r       <= ~sel_r;
        end
      end
      // A completing fill cannot coincide with a meaningful release of the same half
      if (last_s && !sel_r) begin
        full_r[0]    <= 1'b1;
        full_cnt_a_r <= chunk_r;
      end else if (i_rd_release[0]) begin
        full_r[0]    <= 1'b0;
        full_cnt_a_r <= CNT_ZERO;
      end
      if (last_s && sel_r) begin
        full_r[1]    <= 1'b1;
        full_cnt_b_r <= chunk_r;
      end else if (i_rd_release[1]) begin
        full_r[1]    <= 1'b0;
        full_cnt_b_r <= CNT_ZERO;
      end
    end
  end

  // Dword storage; contents survive reset
  always_ff @(posedge clk) begin
    if (accept_s) ram_r[i_buf_addr[CW-1:0]] <= i_buf_dat;
  end

  assign o_xfer_done_stb     = done_r;
  assign o_mrd_req_stb       = req_stb_r;
  assign o_mrd_req_sel       = req_sel_r;
  assign o_mrd_req_dword_cnt = req_cnt_r;
  assign o_buf_rdy           = rdy_r;
  assign o_buf_offset        = offset_r;
  assign o_err_addr          = err_r;
  assign o_buf_full          = full_r;
  assign o_full_cnt_a        = full_cnt_a_r;
  assign o_full_cnt_b        = full_cnt_b_r;
  assign o_rd_dat            = rd_dat_r;

endmodule

// File: tb/tb_pcie_ingress_buffer_mgr.sv
// Bench for pcie_ingress_buffer_mgr: random data and sizes checked against a chunk-list
// model of the transfer plus a flat array model of the dword RAM.
module tb_pcie_ingress_buffer_mgr;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic i_xfer_stb, i_xfer_abort, i_buf_we;
  logic [31:0] i_xfer_dword_size, i_buf_addr, i_buf_dat;
  logic o_xfer_done_stb, o_mrd_req_stb, o_mrd_req_sel, o_buf_rdy, o_err_addr;
  logic [31:0] o_mrd_req_dword_cnt, o_buf_offset, o_rd_dat;
  logic [1:0] o_buf_full, i_rd_release;
  logic [AW:0] o_full_cnt_a, o_full_cnt_b, i_rd_addr;

  int total = 0;
  int bad = 0;
  logic [31:0] mram [0:2*DEPTH-1];
  logic m_sel;
  logic [1:0] m_full;
  int m_cnt_a, m_cnt_b, m_rem;

  pcie_ingress_buffer_mgr #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_xfer_stb(i_xfer_stb), .i_xfer_dword_size(i_xfer_dword_size), .i_xfer_abort(i_xfer_abort),
    .o_xfer_done_stb(o_xfer_done_stb), .o_mrd_req_stb(o_mrd_req_stb), .o_mrd_req_sel(o_mrd_req_sel),
    .o_mrd_req_dword_cnt(o_mrd_req_dword_cnt), .o_buf_rdy(o_buf_rdy), .o_buf_offset(o_buf_offset),
    .i_buf_we(i_buf_we), .i_buf_addr(i_buf_addr), .i_buf_dat(i_buf_dat), .o_err_addr(o_err_addr),
    .o_buf_full(o_buf_full), .o_full_cnt_a(o_full_cnt_a), .o_full_cnt_b(o_full_cnt_b),
    .i_rd_addr(i_rd_addr), .o_rd_dat(o_rd_dat), .i_rd_release(i_rd_release)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sel = 1'b0; m_full = 2'b00; m_cnt_a = 0; m_cnt_b = 0; m_rem = 0;
  endtask

  task automatic start_xfer(input int size);
    i_xfer_dword_size = size;
    i_xfer_stb = 1'b1;
    tick();
    i_xfer_stb = 1'b0;
    m_rem = size;
  endtask

  task automatic wait_req(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (o_mrd_req_stb === 1'b1) begin got = 1'b1; break; end
      tick();
    end
    total++;
    if (!got) begin bad++; $display("FAIL req_timeout: no request within %0d cycles", limit); end
  endtask

  task automatic wait_done(input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (o_xfer_done_stb === 1'b1) begin got = 1'b1; break; end
      tick();
    end
    total++;
    if (!got) begin bad++; $display("FAIL done_timeout: no done pulse within %0d cycles", limit); end
    tick();
    total++;
    if (o_xfer_done_stb !== 1'b0) begin bad++; $display("FAIL done_width: done=%b required 0", o_xfer_done_stb); end
  endtask

  // One chunk: expect the request the model predicts, fill its window, check half flags
  task automatic do_chunk(input bit inject_bad);
    bit got;
    int n, off;
    n   = (m_rem >= DEPTH) ? DEPTH : m_rem;
    off = m_sel ? DEPTH : 0;
    wait_req(200, got);
    if (got) begin
      total++;
      if (o_mrd_req_sel !== m_sel || o_mrd_req_dword_cnt !== n) begin
        bad++; $display("FAIL req_fields: sel=%b cnt=%0d required sel=%b cnt=%0d",
                        o_mrd_req_sel, o_mrd_req_dword_cnt, m_sel, n);
      end
      total++;
      if (o_buf_rdy !== 1'b1 || o_buf_offset !== off) begin
        bad++; $display("FAIL fill_window: rdy=%b off=%0d required rdy=1 off=%0d", o_buf_rdy, o_buf_offset, off);
      end
      if (inject_bad) begin
        i_buf_we = 1'b1; i_buf_addr = m_sel ? 0 : DEPTH; i_buf_dat = $urandom;
        tick();
        i_buf_we = 1'b0;
        total++;
        if (o_err_addr !== 1'b1) begin bad++; $display("FAIL err_addr: err=%b required 1", o_err_addr); end
      end
      for (int k = 0; k < n; k++) begin
        if (k == n - 1) begin
          total++;
          if (o_buf_full[m_sel] !== 1'b0) begin
            bad++; $display("FAIL early_full: half %0d full after %0d writes, required 0", m_sel, k);
          end
        end
        i_buf_we = 1'b1; i_buf_addr = off + k; i_buf_dat = $urandom;
        mram[off + k] = i_buf_dat;
        tick();
      end
      i_buf_we = 1'b0;
    end
    m_full[m_sel] = 1'b1;
    if (m_sel) m_cnt_b = n; else m_cnt_a = n;
    m_sel = ~m_sel;
    m_rem = m_rem - n;
    if (got) begin
      total++;
      if (o_buf_full !== m_full || o_full_cnt_a !== m_cnt_a || o_full_cnt_b !== m_cnt_b || o_buf_rdy !== 1'b0) begin
        bad++; $display("FAIL chunk_end: full=%b a=%0d b=%0d rdy=%b required full=%b a=%0d b=%0d rdy=0",
                        o_buf_full, o_full_cnt_a, o_full_cnt_b, o_buf_rdy, m_full, m_cnt_a, m_cnt_b);
      end
    end
  endtask

  task automatic release_half(input int h);
    i_rd_release = (h == 0) ? 2'b01 : 2'b10;
    tick();
    i_rd_release = 2'b00;
    m_full[h] = 1'b0;
    if (h == 0) m_cnt_a = 0; else m_cnt_b = 0;
    total++;
    if (o_buf_full !== m_full || o_full_cnt_a !== m_cnt_a || o_full_cnt_b !== m_cnt_b) begin
      bad++; $display("FAIL release: full=%b a=%0d b=%0d required full=%b a=%0d b=%0d",
                      o_buf_full, o_full_cnt_a, o_full_cnt_b, m_full, m_cnt_a, m_cnt_b);
    end
  endtask

  task automatic release_all();
    if (m_full[0]) release_half(0);
    if (m_full[1]) release_half(1);
  endtask

  task automatic check_reads(input int n);
    int h, a;
    for (int i = 0; i < n; i++) begin
      if (m_full == 2'b00) break;
      h = $urandom_range(0, 1);
      if (!m_full[h]) h = 1 - h;
      a = h * DEPTH + $urandom_range(0, ((h == 1) ? m_cnt_b : m_cnt_a) - 1);
      i_rd_addr = a[AW:0];
      tick();
      total++;
      if (o_rd_dat !== mram[a]) begin
        bad++; $display("FAIL rd_dat: addr=%0d got=%h required %h", a, o_rd_dat, mram[a]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_xfer_stb = 1'b0; i_xfer_abort = 1'b0; i_xfer_dword_size = 32'd0;
    i_buf_we = 1'b0; i_buf_addr = 32'd0; i_buf_dat = 32'd0; i_rd_addr = '0; i_rd_release = 2'b00;
    repeat (3) tick();
    total++;
    if ({o_xfer_done_stb, o_mrd_req_stb, o_mrd_req_sel, o_mrd_req_dword_cnt, o_buf_rdy, o_buf_offset,
         o_err_addr, o_buf_full, o_full_cnt_a, o_full_cnt_b, o_rd_dat} !== '0) begin
      bad++; $display("FAIL reset_outputs: rdy=%b full=%b err=%b req=%b required all 0",
                      o_buf_rdy, o_buf_full, o_err_addr, o_mrd_req_stb);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_two_chunks();
    start_xfer(600);
    do_chunk(1'b0);
    do_chunk(1'b0);
    wait_done(20);
    check_reads(8);
    release_all();
  endtask

  task automatic test_no_release();
    bit seen = 1'b0;
    start_xfer(1100);
    do_chunk(1'b0);
    do_chunk(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (o_mrd_req_stb !== 1'b0 || o_buf_rdy !== 1'b0) seen = 1'b1;
      tick();
    end
    total++;
    if (seen) begin bad++; $display("FAIL blocked_req: request or rdy while both halves full, required none"); end
    check_reads(4);
    release_half(0);
    total++;
    if (o_mrd_req_stb !== 1'b0) begin bad++; $display("FAIL release_lat1: req=%b required 0", o_mrd_req_stb); end
    tick();
    total++;
    if (o_mrd_req_stb !== 1'b1) begin bad++; $display("FAIL release_lat2: req=%b required 1", o_mrd_req_stb); end
    do_chunk(1'b0);
    wait_done(20);
    release_all();
  endtask

  task automatic test_bad_addr();
    if (m_sel) begin
      start_xfer(1);
      do_chunk(1'b0);
      wait_done(20);
      release_all();
    end
    total++;
    if (o_err_addr !== 1'b0) begin bad++; $display("FAIL err_initial: err=%b required 0", o_err_addr); end
    start_xfer(512);
    do_chunk(1'b1);
    wait_done(20);
    total++;
    if (o_err_addr !== 1'b1) begin bad++; $display("FAIL err_sticky: err=%b required 1", o_err_addr); end
    check_reads(4);
    release_all();
  endtask

  task automatic test_zero_size();
    bit req_seen = 1'b0;
    start_xfer(0);
    if (o_mrd_req_stb !== 1'b0) req_seen = 1'b1;
    total++;
    if (o_xfer_done_stb !== 1'b0) begin bad++; $display("FAIL zero_done1: done=%b required 0", o_xfer_done_stb); end
    tick();
    if (o_mrd_req_stb !== 1'b0) req_seen = 1'b1;
    total++;
    if (o_xfer_done_stb !== 1'b1) begin bad++; $display("FAIL zero_done2: done=%b required 1", o_xfer_done_stb); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_mrd_req_stb !== 1'b0) req_seen = 1'b1;
    end
    total++;
    if (req_seen || o_xfer_done_stb !== 1'b0) begin bad++; $display("FAIL zero_req: request seen for empty transfer"); end
  endtask

  task automatic test_abort();
    bit got;
    bit stray = 1'b0;
    int off;
    start_xfer(700);
    wait_req(50, got);
    off = m_sel ? DEPTH : 0;
    for (int k = 0; k < 100; k++) begin
      i_buf_we = 1'b1; i_buf_addr = off + k; i_buf_dat = $urandom;
      mram[off + k] = i_buf_dat;
      tick();
    end
    i_buf_we = 1'b0;
    i_xfer_abort = 1'b1;
    tick();
    i_xfer_abort = 1'b0;
    m_rem = 0;
    total++;
    if (o_buf_rdy !== 1'b0 || o_buf_full !== 2'b00) begin
      bad++; $display("FAIL abort_state: rdy=%b full=%b required rdy=0 full=00", o_buf_rdy, o_buf_full);
    end
    for (int i = 0; i < 6; i++) begin
      if (o_xfer_done_stb !== 1'b0 || o_mrd_req_stb !== 1'b0) stray = 1'b1;
      tick();
    end
    total++;
    if (stray) begin bad++; $display("FAIL abort_quiet: done or request after abort, required none"); end
    start_xfer(5);
    do_chunk(1'b0);
    wait_done(20);
    check_reads(3);
    release_all();
  endtask

  task automatic test_back_to_back();
    int sizes[5];
    sizes[0] = 512; sizes[1] = 513; sizes[2] = 1024;
    sizes[3] = $urandom_range(1, 1300); sizes[4] = $urandom_range(1, 1300);
    for (int t = 0; t < 5; t++) begin
      start_xfer(sizes[t]);
      while (m_rem > 0) begin
        if (m_full[m_sel]) begin
          check_reads(3);
          release_half(m_sel ? 1 : 0);
        end
        do_chunk(1'b0);
      end
      wait_done(20);
    end
    check_reads(6);
    release_all();
  endtask

  task automatic test_async_rst();
    bit got;
    start_xfer(40);
    wait_req(50, got);
    for (int k = 0; k < 10; k++) begin
      i_buf_we = 1'b1; i_buf_addr = (m_sel ? DEPTH : 0) + k; i_buf_dat = $urandom;
      tick();
    end
    i_buf_we = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({o_xfer_done_stb, o_mrd_req_stb, o_mrd_req_sel, o_mrd_req_dword_cnt, o_buf_rdy, o_buf_offset,
         o_err_addr, o_buf_full, o_full_cnt_a, o_full_cnt_b, o_rd_dat} !== '0) begin
      bad++; $display("FAIL async_rst: rdy=%b off=%0d err=%b full=%b required all 0",
                      o_buf_rdy, o_buf_offset, o_err_addr, o_buf_full);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    start_xfer(3);
    do_chunk(1'b0);
    wait_done(20);
    release_all();
  endtask

  initial begin
    test_reset();
    test_two_chunks();
    test_no_release();
    test_bad_addr();
    test_zero_size();
    test_abort();
    test_back_to_back();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
